// File: rtl/divide_pipe_module.sv
// ---------------------------------------------------------------------------
// divide_pipe_module
//
// Signed Q-format divider: quotient = (dividend << Q_BITS) / divisor.
// The block uses a non-restoring division on operand magnitudes. Each compute
// cycle retires STEPS quotient bits through an unrolled chain. The block adds
// a runtime rounding mode, saturation and divide-by-zero status, and carries
// an opaque tag through with each operation. It sits between the
// intersection input FIFO and the result FIFO, and uses FIFO-style handshakes.
//
// Parameters
//   Q_BITS   fractional bits of operands and result
//   D_BITS   operand/result width (two's complement)
//   STEPS    quotient bits per compute cycle (1, 2, 3 or 6).
//            (D_BITS+Q_BITS) must be a multiple of STEPS.
//   TAG_BITS width of the pass-through tag
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   dividend, divisor    signed Q-format operands
//   round_mode           0 = truncate toward zero,
//                        1 = round half away from zero
//   tag_in               tag sampled with the operands
//   in_empty / in_rd_en  input FIFO status / one-cycle pop
//   quotient             signed Q-format result (registered, holds value)
//   tag_out              tag of the current result
//   status               {overflow, div_zero}
//   out_full / out_wr_en output FIFO status / one-cycle push
//
// Optional build macro: DIVIDE_REMAINDER_EN
//   When this macro is defined, the block adds a signed remainder output.
//   The remainder takes the sign of the dividend and reads 0 on div_zero or
//   overflow. In that build the rounding bias is disabled so that the
//   remainder is exact.
// ---------------------------------------------------------------------------
module divide_pipe_module #(
    parameter int Q_BITS   = 10,
    parameter int D_BITS   = 32,
    parameter int STEPS    = 1,
    parameter int TAG_BITS = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic signed [D_BITS-1:0]   dividend,
    input  logic signed [D_BITS-1:0]   divisor,
    input  logic                       round_mode,
    input  logic [TAG_BITS-1:0]        tag_in,
    input  logic                       in_empty,
    output logic                       in_rd_en,
    output logic signed [D_BITS-1:0]   quotient,
    output logic [TAG_BITS-1:0]        tag_out,
    output logic [1:0]                 status,
`ifdef DIVIDE_REMAINDER_EN
    output logic signed [D_BITS-1:0]   remainder,
`endif
    input  logic                       out_full,
    output logic                       out_wr_en
);

    localparam int N  = D_BITS + Q_BITS;         // iterations per operation
    localparam int C  = N / STEPS;               // compute cycles
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int MW = D_BITS + 1;              // magnitude width, holds 2^(D_BITS-1)
    localparam int RW = D_BITS + 3;              // partial remainder, signed
    localparam logic [D_BITS-1:0] MAX_MAG = {1'b0, {(D_BITS-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [N-1:0]          nq;         // numerator bits shift out of the top, quotient bits shift in at the bottom
    logic signed [RW-1:0]  rem;
    logic [MW-1:0]         dvs_mag;
    logic                  res_neg;    // sign(dividend) ^ sign(divisor)
    logic                  dvd_neg;
    logic                  div_zero;
    logic                  res_ready;  // the first DONE cycle forms the result, and the second cycle offers it
    logic [CW-1:0]         iter;
    logic [TAG_BITS-1:0]   tag_q;

    // Operand magnitudes and the loaded numerator
    logic [MW-1:0]         dvd_ext, dvs_ext_in, dvd_mag_in, dvs_mag_in;
    logic                  round_eff;
    logic [N-1:0]          load_num;

    // NOTE: every signal that always_comb writes gets a default value first,
    //       so that no path can leave the signal unassigned and infer a latch.
    always_comb begin
        dvd_ext    = {dividend[D_BITS-1], dividend};
        dvs_ext_in = {divisor[D_BITS-1], divisor};
        dvd_mag_in = dividend[D_BITS-1] ? -dvd_ext : dvd_ext;
        dvs_mag_in = divisor[D_BITS-1]  ? -dvs_ext_in : dvs_ext_in;
`ifdef DIVIDE_REMAINDER_EN
        round_eff  = 1'b0;
`else
        round_eff  = round_mode;
`endif
        // The largest magnitude 2^(D_BITS-1) shifted by Q_BITS, plus the
        // half-divisor bias, still fits in N bits.
        load_num   = N'({dvd_mag_in, {Q_BITS{1'b0}}});
        if (round_eff)
            load_num = load_num + N'(dvs_mag_in >> 1);
    end

    // Unrolled non-restoring chain. The sign of the trial remainder selects
    // add or subtract, and each new quotient bit is the inverted sign.
    logic signed [RW-1:0] dvs_ext, step_rem, trial, corr_rem;
    logic [N-1:0]         step_nq;

    always_comb begin
        dvs_ext  = {{(RW-MW){1'b0}}, dvs_mag};
        step_rem = rem;
        step_nq  = nq;
        trial    = '0;
        for (int s = 0; s < STEPS; s++) begin
            trial    = {step_rem[RW-2:0], step_nq[N-1]};
            step_rem = step_rem[RW-1] ? (trial + dvs_ext) : (trial - dvs_ext);
            step_nq  = {step_nq[N-2:0], ~step_rem[RW-1]};
        end
        corr_rem = step_rem[RW-1] ? (step_rem + dvs_ext) : step_rem;
    end

    // Saturate and sign the finished magnitude
    logic                fin_ovf, fin_neg;
    logic [D_BITS-1:0]   fin_mag, fin_q;
`ifdef DIVIDE_REMAINDER_EN
    logic [D_BITS-1:0]   rem_mag, fin_rem;
`endif

    always_comb begin
        fin_ovf = 1'b0;
        fin_mag = MAX_MAG;
        fin_neg = dvd_neg;
        if (!div_zero) begin
            fin_ovf = |nq[N-1:D_BITS-1];
            fin_mag = fin_ovf ? MAX_MAG : nq[D_BITS-1:0];
            fin_neg = res_neg;
        end
        fin_q = fin_neg ? -fin_mag : fin_mag;
`ifdef DIVIDE_REMAINDER_EN
        rem_mag = rem[D_BITS-1:0];
        fin_rem = (div_zero || fin_ovf) ? '0 : (dvd_neg ? -rem_mag : rem_mag);
`endif
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    //       All registers then sample pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nq        <= '0;
            rem       <= '0;
            dvs_mag   <= '0;
            res_neg   <= 1'b0;
            dvd_neg   <= 1'b0;
            div_zero  <= 1'b0;
            res_ready <= 1'b0;
            iter      <= '0;
            tag_q     <= '0;
            in_rd_en  <= 1'b0;
            out_wr_en <= 1'b0;
            quotient  <= '0;
            tag_out   <= '0;
            status    <= '0;
`ifdef DIVIDE_REMAINDER_EN
            remainder <= '0;
`endif
        end else begin
            in_rd_en  <= 1'b0;
            out_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!in_empty) begin
                        in_rd_en  <= 1'b1;
                        res_neg   <= dividend[D_BITS-1] ^ divisor[D_BITS-1];
                        dvd_neg   <= dividend[D_BITS-1];
                        dvs_mag   <= dvs_mag_in;
                        tag_q     <= tag_in;
                        nq        <= load_num;
                        rem       <= '0;
                        iter      <= '0;
                        res_ready <= 1'b0;
                        div_zero  <= (divisor == '0);
                        state     <= (divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    nq   <= step_nq;
                    iter <= iter + 1'b1;
                    if (iter == CW'(C - 1)) begin
                        rem   <= corr_rem;
                        state <= DONE;
                    end else begin
                        rem   <= step_rem;
                    end
                end
                DONE: begin
                    if (!res_ready) begin
                        res_ready <= 1'b1;
                    end else if (!out_full) begin
                        out_wr_en <= 1'b1;
                        quotient  <= fin_q;
                        tag_out   <= tag_q;
                        status    <= {fin_ovf, div_zero};
`ifdef DIVIDE_REMAINDER_EN
                        remainder <= fin_rem;
`endif
                        res_ready <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
